// File: rtl/apb_pkg.sv
// Shared definitions for the APB-to-memory bridge.
//   apb_bridge_state_t : bridge FSM state encoding
//   in_range()         : address window test, base <= addr < base+depth
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } apb_bridge_state_t;

    // Subtracting before comparing avoids overflow of base+depth at the top
    // of the address space.
    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] depth);
        logic hit_s;
        if (addr >= base) begin
            hit_s = ((addr - base) < depth);
        end else begin
            hit_s = 1'b0;
        end
        return hit_s;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state timer for the memory handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : force the count to zero
//   enable_i   : advance the count by one (saturating, never wraps)
//   expire_o   : count has reached TIMEOUT-1; never asserted when TIMEOUT==0
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));
    localparam logic [CNT_W-1:0] MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear wins, otherwise count up and hold at the maximum.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (enable_i && (count_q != MAX)) begin
            count_d = count_q + CNT_W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (TIMEOUT != 0) && (count_q == LAST);

endmodule

// File: rtl/apb_mem_bridge.sv
// APB slave bridging transfers onto a simple memory port.
//   APB side   : psel/penable/pwrite/paddr/pwdata/pstrb in, pready/prdata/pslverr out
//   Memory side: mem_ce/mem_rden/mem_wren/mem_addr/mem_wdata/mem_wstrb out,
//                mem_rdata/mem_ready in
// Addresses outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH) answer with PSLVERR and
// never touch the memory. A memory that does not answer within TIMEOUT
// cycles also ends in PSLVERR (TIMEOUT==0 waits forever).
module apb_mem_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic                pready,
    output logic [DATA_W-1:0]   prdata,
    output logic                pslverr,
    output logic                mem_ce,
    output logic                mem_rden,
    output logic                mem_wren,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);

    localparam int unsigned     STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    apb_bridge_state_t state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;

    logic setup_s, hit_s, req_s;
    logic tmr_clear_s, tmr_en_s, tmr_expire_s;

    assign setup_s = psel & ~penable;
    assign hit_s   = in_range(64'(paddr), 64'(BASE_ADDR), 64'(MEM_DEPTH));
    assign req_s   = (state_q == REQ);

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (tmr_clear_s),
        .enable_i (tmr_en_s),
        .expire_o (tmr_expire_s)
    );

    // Transfer FSM and request latching.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        prdata_d    = prdata_q;
        tmr_clear_s = 1'b0;
        tmr_en_s    = 1'b0;
        case (state_q)
            IDLE: begin
                prdata_d = {DATA_W{1'b0}};
                if (setup_s) begin
                    write_d     = pwrite;
                    addr_d      = paddr - BASE_A;
                    wdata_d     = pwdata;
                    strb_d      = pstrb;
                    tmr_clear_s = 1'b1;
                    if (hit_s) begin
                        state_d = REQ;
                    end else begin
                        state_d = ERR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // A dropped psel is a master abort: leave silently.
                if (!psel) begin
                    prdata_d = {DATA_W{1'b0}};
                    state_d  = IDLE;
                end else if (mem_ready) begin
                    prdata_d = write_q ? {DATA_W{1'b0}} : mem_rdata;
                    state_d  = DONE;
                end else if (tmr_expire_s) begin
                    prdata_d = {DATA_W{1'b0}};
                    state_d  = ERR;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            DONE: begin
                // prdata is only valid for the single pready cycle.
                prdata_d = {DATA_W{1'b0}};
                state_d  = IDLE;
            end
            ERR: begin
                prdata_d = {DATA_W{1'b0}};
                state_d  = IDLE;
            end
            default: begin
                prdata_d = {DATA_W{1'b0}};
                state_d  = IDLE;
            end
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            strb_q   <= {STRB_W{1'b0}};
            prdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            prdata_q <= prdata_d;
        end
    end

    // Memory port is quiet outside REQ so reset or abort silences it at once.
    assign mem_ce    = req_s;
    assign mem_wren  = req_s & write_q;
    assign mem_rden  = req_s & ~write_q;
    assign mem_addr  = req_s ? addr_q  : {ADDR_W{1'b0}};
    assign mem_wdata = req_s ? wdata_q : {DATA_W{1'b0}};
    assign mem_wstrb = req_s ? (write_q ? strb_q : {STRB_W{1'b1}}) : {STRB_W{1'b0}};

    assign pready  = (state_q == DONE) || (state_q == ERR);
    assign pslverr = (state_q == ERR);
    assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Bench for apb_mem_bridge: two instances (full-window 32-bit, and a small
// window at 16..31 with a 3-cycle timeout) each with a stallable memory.
module tb_apb_mem_bridge;

    typedef struct {
        int          sel;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          stall;
        bit          err;
        logic [31:0] rdata;
        int          lat;
        int          ce;
        logic [7:0]  maddr;
        logic [3:0]  wstrb;
    } vec_t;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
    } sb_t;

    localparam int NV = 17;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel [2];
    logic        penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready [2], pslverr [2];
    logic        mem_ce [2], mem_rden [2], mem_wren [2], mem_ready [2];
    logic [31:0] prdata [2], mem_wdata [2], mem_rdata [2];
    logic [7:0]  mem_addr [2];
    logic [3:0]  mem_wstrb [2];
    int          stall_tgt [2];

    int   checks, errors;
    sb_t  sb_q [$];
    vec_t vecs [NV];

    int          o_lat, o_ce, o_wren, o_rden, bad;
    logic [7:0]  o_maddr;
    logic [3:0]  o_wstrb;
    bit          o_done;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bit [31:0] mem [256];
        int        req_cnt = 0;

        apb_mem_bridge #(
            .ADDR_W    (8),
            .DATA_W    (32),
            .BASE_ADDR ((g == 0) ? 0 : 16),
            .MEM_DEPTH ((g == 0) ? 256 : 16),
            .TIMEOUT   ((g == 0) ? 16 : 3)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .psel      (psel[g]),
            .penable   (penable),
            .pwrite    (pwrite),
            .paddr     (paddr),
            .pwdata    (pwdata),
            .pstrb     (pstrb),
            .pready    (pready[g]),
            .prdata    (prdata[g]),
            .pslverr   (pslverr[g]),
            .mem_ce    (mem_ce[g]),
            .mem_rden  (mem_rden[g]),
            .mem_wren  (mem_wren[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_wstrb (mem_wstrb[g]),
            .mem_rdata (mem_rdata[g]),
            .mem_ready (mem_ready[g])
        );

        // Memory answers after stall_tgt cycles of mem_ce.
        assign mem_ready[g] = (req_cnt >= stall_tgt[g]);
        assign mem_rdata[g] = mem[mem_addr[g]];

        // Memory model: stall counter and byte-masked write.
        always @(posedge clk) begin
            if (mem_ce[g]) req_cnt <= req_cnt + 1;
            else           req_cnt <= 0;
            if (mem_ce[g] && mem_wren[g] && mem_ready[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[g][b]) mem[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag, input int sel);
        check({tag, " pready"},    64'(pready[sel]),    64'd0);
        check({tag, " pslverr"},   64'(pslverr[sel]),   64'd0);
        check({tag, " prdata"},    64'(prdata[sel]),    64'd0);
        check({tag, " strobes"},   64'({mem_ce[sel], mem_rden[sel], mem_wren[sel]}), 64'd0);
        check({tag, " mem_addr"},  64'(mem_addr[sel]),  64'd0);
        check({tag, " mem_wdata"}, 64'(mem_wdata[sel]), 64'd0);
        check({tag, " mem_wstrb"}, 64'(mem_wstrb[sel]), 64'd0);
    endtask

    // One APB transfer; expected response is queued now, checked at pready.
    task automatic run_xfer(input string tag, input int sel, input bit wr,
                            input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int stall, input bit exp_err, input logic [31:0] exp_rd);
        sb_t e;
        e.err   = exp_err;
        e.rdata = exp_rd;
        sb_q.push_back(e);
        stall_tgt[sel] = stall;
        @(posedge clk); #1;
        psel[0] = (sel == 0);
        psel[1] = (sel == 1);
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        o_lat = 0; o_ce = 0; o_wren = 0; o_rden = 0;
        o_maddr = 8'd0; o_wstrb = 4'd0; o_done = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (mem_ce[sel]) begin
                o_ce++;
                o_maddr = mem_addr[sel];
                o_wstrb = mem_wstrb[sel];
            end
            if (mem_wren[sel]) o_wren++;
            if (mem_rden[sel]) o_rden++;
            if (pready[sel]) begin
                o_done = 1'b1;
                o_lat  = cyc;
                e = sb_q.pop_front();
                check({tag, " pslverr"}, 64'(pslverr[sel]), 64'(e.err));
                check({tag, " prdata"},  64'(prdata[sel]),  64'(e.rdata));
                break;
            end
        end
        if (!o_done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: pready not seen within 40 cycles", tag);
            e = sb_q.pop_front();
            psel[sel] = 1'b0;
            penable   = 1'b0;
        end
    endtask

    initial begin
        checks = 0; errors = 0; rst_n = 1'b0;
        psel[0] = 1'b0; psel[1] = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'd0; pwdata = 32'd0; pstrb = 4'd0;
        stall_tgt[0] = 0; stall_tgt[1] = 0;

        //          sel wr  addr    wdata          strb  stall err rdata          lat ce maddr  wstrb
        vecs[0]  = '{0, 1'b1, 8'd6,   32'd5,         4'h1, 0,    1'b0, 32'd0,         2, 1, 8'd6,  4'h1};
        vecs[1]  = '{0, 1'b0, 8'd6,   32'd0,         4'h0, 0,    1'b0, 32'd5,         2, 1, 8'd6,  4'hF};
        vecs[2]  = '{0, 1'b1, 8'd5,   32'd4,         4'hF, 5,    1'b0, 32'd0,         7, 6, 8'd5,  4'hF};
        vecs[3]  = '{0, 1'b0, 8'd5,   32'd0,         4'h0, 5,    1'b0, 32'd4,         7, 6, 8'd5,  4'hF};
        vecs[4]  = '{0, 1'b1, 8'h20,  32'h11223344,  4'hF, 0,    1'b0, 32'd0,         2, 1, 8'h20, 4'hF};
        vecs[5]  = '{0, 1'b1, 8'h20,  32'hAABBCCDD,  4'h5, 0,    1'b0, 32'd0,         2, 1, 8'h20, 4'h5};
        vecs[6]  = '{0, 1'b0, 8'h20,  32'd0,         4'h0, 0,    1'b0, 32'h11BB33DD,  2, 1, 8'h20, 4'hF};
        vecs[7]  = '{0, 1'b1, 8'h20,  32'hFFFFFFFF,  4'h0, 0,    1'b0, 32'd0,         2, 1, 8'h20, 4'h0};
        vecs[8]  = '{0, 1'b0, 8'h20,  32'd0,         4'h0, 0,    1'b0, 32'h11BB33DD,  2, 1, 8'h20, 4'hF};
        vecs[9]  = '{1, 1'b0, 8'd40,  32'd0,         4'h0, 0,    1'b1, 32'd0,         1, 0, 8'd0,  4'h0};
        vecs[10] = '{1, 1'b0, 8'd15,  32'd0,         4'h0, 0,    1'b1, 32'd0,         1, 0, 8'd0,  4'h0};
        vecs[11] = '{1, 1'b1, 8'd32,  32'h99,        4'hF, 0,    1'b1, 32'd0,         1, 0, 8'd0,  4'h0};
        vecs[12] = '{1, 1'b1, 8'd31,  32'h77,        4'hF, 0,    1'b0, 32'd0,         2, 1, 8'd15, 4'hF};
        vecs[13] = '{1, 1'b0, 8'd31,  32'd0,         4'h0, 0,    1'b0, 32'h77,        2, 1, 8'd15, 4'hF};
        vecs[14] = '{1, 1'b0, 8'd20,  32'd0,         4'h0, 1000, 1'b1, 32'd0,         4, 3, 8'd4,  4'hF};
        vecs[15] = '{1, 1'b1, 8'd16,  32'd9,         4'hF, 2,    1'b0, 32'd0,         4, 3, 8'd0,  4'hF};
        vecs[16] = '{1, 1'b0, 8'd16,  32'd0,         4'h0, 2,    1'b0, 32'd9,         4, 3, 8'd0,  4'hF};

        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset0", 0);
        check_quiet("reset1", 1);
        rst_n = 1'b1;

        // Access phase without a setup phase must be ignored.
        @(posedge clk); #1;
        psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd3;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ce[0] || pready[0]) bad++;
        end
        check("idle_no_setup", 64'(bad), 64'd0);
        @(posedge clk); #1;
        psel[0] = 1'b0; penable = 1'b0;

        for (int i = 0; i < NV; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            run_xfer(t, vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                     vecs[i].stall, vecs[i].err, vecs[i].rdata);
            check({t, " latency"},   64'(o_lat),  64'(vecs[i].lat));
            check({t, " ce_cycles"}, 64'(o_ce),   64'(vecs[i].ce));
            check({t, " wren"},      64'(o_wren), 64'(vecs[i].wr ? vecs[i].ce : 0));
            check({t, " rden"},      64'(o_rden), 64'(vecs[i].wr ? 0 : vecs[i].ce));
            if (vecs[i].ce > 0) begin
                check({t, " mem_addr"},  64'(o_maddr), 64'(vecs[i].maddr));
                check({t, " mem_wstrb"}, 64'(o_wstrb), 64'(vecs[i].wstrb));
            end
        end
        @(posedge clk); #1;
        psel[0] = 1'b0; psel[1] = 1'b0; penable = 1'b0;

        // Master abort: psel drops while the memory is stalling.
        stall_tgt[0] = 1000;
        @(posedge clk); #1;
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd9;
        pwdata = 32'h55; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("abort_req_ce", 64'(mem_ce[0]), 64'd1);
        @(posedge clk); #1;
        psel[0] = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort_req_hold", 64'(mem_ce[0]), 64'd1);
        @(negedge clk);
        check("abort_ce_drop", 64'(mem_ce[0]), 64'd0);
        bad = pready[0] ? 1 : 0;
        repeat (3) begin
            @(negedge clk);
            if (pready[0] || mem_ce[0]) bad++;
        end
        check("abort_no_pready", 64'(bad), 64'd0);
        run_xfer("abort_readback", 0, 1'b0, 8'd9, 32'd0, 4'h0, 0, 1'b0, 32'd0);
        check("abort_readback latency", 64'(o_lat), 64'd2);

        // Asynchronous reset in the middle of a stalled request.
        stall_tgt[0] = 1000;
        @(posedge clk); #1;
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd10;
        pwdata = 32'hC0FFEE; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("rst_req_ce", 64'(mem_ce[0]), 64'd1);
        #1 rst_n = 1'b0;
        #1 check_quiet("rst_mid", 0);
        @(posedge clk); #1;
        psel[0] = 1'b0; penable = 1'b0; rst_n = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_ce[0] || pready[0]) bad++;
        end
        check("rst_no_access", 64'(bad), 64'd0);
        run_xfer("rst_readback", 0, 1'b0, 8'd10, 32'd0, 4'h0, 0, 1'b0, 32'd0);
        check("rst_readback latency", 64'(o_lat), 64'd2);
        run_xfer("rst_write", 0, 1'b1, 8'd10, 32'hC0FFEE, 4'hF, 0, 1'b0, 32'd0);
        run_xfer("rst_read", 0, 1'b0, 8'd10, 32'd0, 4'h0, 0, 1'b0, 32'hC0FFEE);
        @(posedge clk); #1;
        psel[0] = 1'b0; penable = 1'b0;

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
